// File: rtl/qs1r_fir_pkg.sv
// qs1r_fir_pkg: shared constants and types for the dual I/Q FIR decimator
// sequencer (sample width, default pass geometry, sequencer state encoding).

package qs1r_fir_pkg;

    localparam int SAMPLE_W       = 24;
    localparam int DEF_TAPS       = 256;
    localparam int DEF_AW         = 8;
    localparam int DEF_GAP        = DEF_TAPS + 8;
    localparam int DEF_COEFF_LEAD = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } fir_state_e;

endpackage

// File: rtl/qs1r_fir_ctrl_fifo.sv
// qs1r_fir_ctrl_fifo: small synchronous FIFO buffering {i,q} sample words
// between the CIC decimators and the FIR start sequencer. A push into a full
// FIFO is only accepted when a pop happens in the same cycle.

module qs1r_fir_ctrl_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 48,
    localparam int LW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW:0]      level,
    output logic             full,
    output logic             empty
);

    localparam logic [LW-1:0] PTR_ONE  = LW'(1);
    localparam logic [LW:0]   LVL_ONE  = (LW + 1)'(1);
    localparam logic [LW:0]   LVL_FULL = (LW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_FULL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy tracking; push+pop together leaves the level unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Sample storage; contents need no reset since level gates every read.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/qs1r_fir_ctrl.sv
// qs1r_fir_ctrl: start sequencer for the I and Q FIR decimator engines.
// Buffers CIC samples, issues one fir_start per sample no closer than GAP
// cycles apart, drives the coefficient read address in step with the taps,
// and forwards host coefficient writes to the coefficient RAM.
// Build option QS1R_FIR_CTRL_BANK_EN: double-buffered coefficient banks with
// host writes to the inactive bank and a deferred bank swap; without it a
// single live bank is used and coef_swap is ignored.
//
// state | meaning
// HOLD  | after reset: wait GAP cycles for FIRs (no reset) to finish any pass
// IDLE  | ready; start a pass as soon as the FIFO holds a sample
// RUN   | MAC pass in flight; counter sweeps the coefficient address

module qs1r_fir_ctrl
    import qs1r_fir_pkg::*;
#(
    parameter int TAPS       = DEF_TAPS,
    parameter int AW         = DEF_AW,
    parameter int GAP        = DEF_GAP,
    parameter int COEFF_LEAD = DEF_COEFF_LEAD,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_strobe,
    input  logic [SAMPLE_W-1:0]           in_i,
    input  logic [SAMPLE_W-1:0]           in_q,
    output logic                          fir_start,
    output logic [SAMPLE_W-1:0]           fir_in_i,
    output logic [SAMPLE_W-1:0]           fir_in_q,
    output logic [AW:0]                   coeff_addr,
    input  logic                          coef_wr,
    input  logic [AW-1:0]                 coef_wr_addr,
    input  logic [SAMPLE_W-1:0]           coef_wr_data,
    output logic                          coef_we,
    output logic [AW:0]                   coef_waddr,
    output logic [SAMPLE_W-1:0]           coef_wdata,
    input  logic                          coef_swap,
    output logic                          coef_swap_ack,
    output logic                          active_bank,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          ovr_clr
);

    localparam int CW = $clog2(GAP + 1);

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(GAP - 1);
    localparam logic [CW-1:0] RUN_LAST   = CW'(GAP - 2);
    localparam logic [CW-1:0] TAP_FIRST  = CW'(COEFF_LEAD);
    localparam logic [CW-1:0] TAP_LAST   = CW'(TAPS + COEFF_LEAD - 2);
    localparam logic [CW-1:0] TAP_OFFSET = CW'(COEFF_LEAD - 1);

    fir_state_e              state;
    fir_state_e              state_next;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;
    logic                    issue;
    logic [AW-1:0]           tap_q;
    logic [AW-1:0]           tap_next;
    logic                    bank;
    logic                    wr_bank;

    logic [2*SAMPLE_W-1:0]   fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_drop;

    qs1r_fir_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * SAMPLE_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (in_strobe),
        .pop     (issue),
        .wr_data ({in_i, in_q}),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_drop  = in_strobe & fifo_full & ~issue;
    assign coeff_addr = {bank, tap_q};
    assign active_bank = bank;

    // Next state, pass counter and tap index. RUN is left one count early so
    // the counter reads GAP-1 in the IDLE cycle, which lets the next start
    // land exactly GAP cycles after the previous one.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        issue      = 1'b0;
        tap_next   = '0;
        case (state)
            HOLD: begin
                cnt_next = cnt + CNT_ONE;
                if (cnt == HOLD_LAST) state_next = IDLE;
            end
            IDLE: begin
                if (!fifo_empty) begin
                    issue      = 1'b1;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_next = cnt + CNT_ONE;
                if (cnt == RUN_LAST) state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = HOLD;
            end
        endcase
        if (state_next == RUN && cnt_next >= TAP_FIRST && cnt_next <= TAP_LAST)
            tap_next = AW'(cnt_next - TAP_OFFSET);
    end

    // Sequencer registers and the registered FIR-facing outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= HOLD;
            cnt       <= '0;
            fir_start <= 1'b0;
            fir_in_i  <= '0;
            fir_in_q  <= '0;
            busy      <= 1'b1;
            tap_q     <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            fir_start <= issue;
            busy      <= (state_next != IDLE);
            tap_q     <= tap_next;
            if (issue) begin
                fir_in_i <= fifo_head[2*SAMPLE_W-1:SAMPLE_W];
                fir_in_q <= fifo_head[SAMPLE_W-1:0];
            end
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset)          overrun <= 1'b0;
        else if (fifo_drop) overrun <= 1'b1;
        else if (ovr_clr)   overrun <= 1'b0;
    end

    // Host coefficient write forwarding, one cycle behind the request.
    always_ff @(posedge clock) begin
        if (reset) begin
            coef_we    <= 1'b0;
            coef_waddr <= '0;
            coef_wdata <= '0;
        end else begin
            coef_we <= coef_wr;
            if (coef_wr) begin
                coef_waddr <= {wr_bank, coef_wr_addr};
                coef_wdata <= coef_wr_data;
            end
        end
    end

`ifdef QS1R_FIR_CTRL_BANK_EN
    logic swap_pend;
    logic swap_go;

    // Swaps only land while no pass can be reading coefficients.
    assign swap_go = swap_pend & ((state == HOLD) | ((state == IDLE) & ~issue));
    assign wr_bank = ~bank;

    // Pending swap request, live bank select and the swap acknowledge pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            swap_pend     <= 1'b0;
            bank          <= 1'b0;
            coef_swap_ack <= 1'b0;
        end else begin
            swap_pend     <= (swap_pend & ~swap_go) | coef_swap;
            coef_swap_ack <= swap_go;
            if (swap_go) bank <= ~bank;
        end
    end
`else
    logic unused_swap;

    assign unused_swap   = coef_swap;
    assign bank          = 1'b0;
    assign wr_bank       = 1'b0;
    assign coef_swap_ack = 1'b0;
`endif

endmodule

// File: tb/tb_qs1r_fir_ctrl.sv
// Directed bench for qs1r_fir_ctrl; covers the banked and single-bank builds
// depending on QS1R_FIR_CTRL_BANK_EN.

module tb_qs1r_fir_ctrl;

    localparam int TAPS = 256;
    localparam int GAP  = 264;
`ifdef QS1R_FIR_CTRL_BANK_EN
    localparam logic BANK_EN = 1'b1;
`else
    localparam logic BANK_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        in_strobe;
    logic [23:0] in_i;
    logic [23:0] in_q;
    logic        fir_start;
    logic [23:0] fir_in_i;
    logic [23:0] fir_in_q;
    logic [8:0]  coeff_addr;
    logic        coef_wr;
    logic [7:0]  coef_wr_addr;
    logic [23:0] coef_wr_data;
    logic        coef_we;
    logic [8:0]  coef_waddr;
    logic [23:0] coef_wdata;
    logic        coef_swap;
    logic        coef_swap_ack;
    logic        active_bank;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        overrun;
    logic        ovr_clr;

    int vectors    = 0;
    int miscompares = 0;

    qs1r_fir_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .in_strobe     (in_strobe),
        .in_i          (in_i),
        .in_q          (in_q),
        .fir_start     (fir_start),
        .fir_in_i      (fir_in_i),
        .fir_in_q      (fir_in_q),
        .coeff_addr    (coeff_addr),
        .coef_wr       (coef_wr),
        .coef_wr_addr  (coef_wr_addr),
        .coef_wr_data  (coef_wr_data),
        .coef_we       (coef_we),
        .coef_waddr    (coef_waddr),
        .coef_wdata    (coef_wdata),
        .coef_swap     (coef_swap),
        .coef_swap_ack (coef_swap_ack),
        .active_bank   (active_bank),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .overrun       (overrun),
        .ovr_clr       (ovr_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (busy === 1'b0 && fifo_level === 3'd0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (fir_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_strobe = 1'b0; in_i = '0; in_q = '0;
        coef_wr = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
        coef_swap = 1'b0; ovr_clr = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        vectors++;
        if ({fir_start, coef_we, coef_swap_ack, overrun, active_bank, busy} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000001",
                     {fir_start, coef_we, coef_swap_ack, overrun, active_bank, busy});
        end
        vectors++;
        if (fir_in_i !== 24'h0 || fir_in_q !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_fir_in: got %h/%h expected 000000/000000", fir_in_i, fir_in_q);
        end
        vectors++;
        if (coeff_addr !== 9'h000 || fifo_level !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_addr_level: got %h/%0d expected 000/0", coeff_addr, fifo_level);
        end
    endtask

    // Starts at cycle 0 of HOLD.
    task automatic test_first_sample();
        bit bad = 1'b0;
        repeat (5) step();
        in_strobe = 1'b1; in_i = 24'h000123; in_q = 24'hFFFEDC;
        step();
        in_strobe = 1'b0;
        for (int c = 6; c < GAP; c++) begin
            if (fir_start !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            step();
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL hold_gate: got start/busy activity during HOLD expected start=0 busy=1");
        end
        vectors++;
        if (busy !== 1'b0 || fir_start !== 1'b0 || fifo_level !== 3'd1) begin
            miscompares++;
            $display("FAIL hold_end: got busy=%b start=%b level=%0d expected 0 0 1",
                     busy, fir_start, fifo_level);
        end
        step();
        vectors++;
        if (fir_start !== 1'b1 || fir_in_i !== 24'h000123 || fir_in_q !== 24'hFFFEDC) begin
            miscompares++;
            $display("FAIL first_start: got %b %h %h expected 1 000123 fffedc",
                     fir_start, fir_in_i, fir_in_q);
        end
        step();
        vectors++;
        if (fir_start !== 1'b0 || fifo_level !== 3'd0) begin
            miscompares++;
            $display("FAIL first_pulse_width: got start=%b level=%0d expected 0 0", fir_start, fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] si [3];
        logic [23:0] sq [3];
        int          starts[$];
        int          k = 0;
        bit          seen = 1'b0;
        bit          bad = 1'b0;
        bit          ok;
        int          bad_c = 0;
        logic [8:0]  exp_addr;
        logic [8:0]  bad_got = '0;
        logic [8:0]  bad_exp = '0;
        si[0] = 24'h100001; si[1] = 24'h200002; si[2] = 24'h300003;
        sq[0] = 24'hA00001; sq[1] = 24'hB00002; sq[2] = 24'hC00003;
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_idle_timeout: got busy=%b expected 0", busy);
        end
        for (int c = 0; c < 3 * GAP + 10; c++) begin
            if (c < 3) begin
                in_strobe = 1'b1; in_i = si[c]; in_q = sq[c];
            end else begin
                in_strobe = 1'b0;
            end
            step();
            if (fir_start === 1'b1) begin
                if (starts.size() < 3) begin
                    vectors++;
                    if (fir_in_i !== si[starts.size()] || fir_in_q !== sq[starts.size()]) begin
                        miscompares++;
                        $display("FAIL b2b_data%0d: got %h/%h expected %h/%h", starts.size(),
                                 fir_in_i, fir_in_q, si[starts.size()], sq[starts.size()]);
                    end
                end
                starts.push_back(c);
                k = 0;
                seen = 1'b1;
            end else if (seen) begin
                k++;
            end
            exp_addr = (seen && k >= 2 && k <= TAPS) ? 9'(k - 1) : 9'd0;
            if (coeff_addr !== exp_addr && !bad) begin
                bad = 1'b1; bad_c = c; bad_got = coeff_addr; bad_exp = exp_addr;
            end
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL b2b_coeff_addr: at step %0d got %h expected %h", bad_c, bad_got, bad_exp);
        end
        vectors++;
        if (starts.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_start_count: got %0d expected 3", starts.size());
        end else begin
            vectors++;
            if (starts[0] != 1) begin
                miscompares++;
                $display("FAIL b2b_latency: got %0d expected 1", starts[0]);
            end
            vectors++;
            if (starts[1] - starts[0] != GAP || starts[2] - starts[1] != GAP) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d,%0d expected %0d,%0d",
                         starts[1] - starts[0], starts[2] - starts[1], GAP, GAP);
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ovr_idle_timeout: got busy=%b expected 0", busy);
        end
        for (int c = 0; c < 6; c++) begin
            in_strobe = 1'b1; in_i = 24'(c + 16); in_q = 24'(c + 32);
            if (c == 5) begin
                vectors++;
                if (fifo_level !== 3'd4 || overrun !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovr_full: got level=%0d overrun=%b expected 4 0", fifo_level, overrun);
                end
            end
            step();
        end
        in_strobe = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_drop: got level=%0d overrun=%b expected 4 1", fifo_level, overrun);
        end
        in_strobe = 1'b1; ovr_clr = 1'b1;
        step();
        in_strobe = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || fifo_level !== 3'd4) begin
            miscompares++;
            $display("FAIL ovr_set_wins: got overrun=%b level=%0d expected 1 4", overrun, fifo_level);
        end
        step();
        ovr_clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear: got %b expected 0", overrun);
        end
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        in_strobe = 1'b1; in_i = 24'h0000AA; in_q = 24'h0000BB;
        step();
        in_strobe = 1'b0;
        vectors++;
        if (!ok || fifo_level !== 3'd4 || overrun !== 1'b0 || fir_start !== 1'b1) begin
            miscompares++;
            $display("FAIL full_push_pop: got ok=%b level=%0d overrun=%b start=%b expected 1 4 0 1",
                     ok, fifo_level, overrun, fir_start);
        end
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ovr_drain_timeout: got level=%0d expected 0", fifo_level);
        end
    endtask

    task automatic test_swap();
        bit         ok;
        bit         bad = 1'b0;
        logic [8:0] exp_w;
        wait_idle(ok);
        in_strobe = 1'b1; in_i = 24'h055555; in_q = 24'h0AAAAA;
        step();
        in_strobe = 1'b0;
        wait_start(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL swap_start_timeout: got start=%b expected 1", fir_start);
        end
        repeat (10) step();
        coef_wr = 1'b1; coef_wr_addr = 8'h10; coef_wr_data = 24'h7FFFFF;
        step();
        coef_wr = 1'b0;
        exp_w = BANK_EN ? 9'h110 : 9'h010;
        vectors++;
        if (coef_we !== 1'b1 || coef_waddr !== exp_w || coef_wdata !== 24'h7FFFFF) begin
            miscompares++;
            $display("FAIL host_write: got we=%b addr=%h data=%h expected 1 %h 7fffff",
                     coef_we, coef_waddr, coef_wdata, exp_w);
        end
        step();
        vectors++;
        if (coef_we !== 1'b0) begin
            miscompares++;
            $display("FAIL host_write_pulse: got %b expected 0", coef_we);
        end
        coef_swap = 1'b1;
        step();
        coef_swap = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            if (coef_swap_ack !== 1'b0 || active_bank !== 1'b0) bad = 1'b1;
            step();
        end
        vectors++;
        if (!ok || bad || coef_swap_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_in_run: got ok=%b early=%b ack=%b expected 1 0 0", ok, bad, coef_swap_ack);
        end
        coef_wr = 1'b1; coef_wr_addr = 8'h22; coef_wr_data = 24'h123456;
        step();
        coef_wr = 1'b0;
        exp_w = BANK_EN ? 9'h122 : 9'h022;
        vectors++;
        if (coef_swap_ack !== BANK_EN || active_bank !== BANK_EN || coef_waddr !== exp_w) begin
            miscompares++;
            $display("FAIL swap_exec: got ack=%b bank=%b waddr=%h expected %b %b %h",
                     coef_swap_ack, active_bank, coef_waddr, BANK_EN, BANK_EN, exp_w);
        end
        coef_wr = 1'b1; coef_wr_addr = 8'h33; coef_wr_data = 24'h000001;
        step();
        coef_wr = 1'b0;
        vectors++;
        if (coef_swap_ack !== 1'b0 || coef_waddr !== 9'h033) begin
            miscompares++;
            $display("FAIL swap_after: got ack=%b waddr=%h expected 0 033", coef_swap_ack, coef_waddr);
        end
        in_strobe = 1'b1; in_i = 24'h000777; in_q = 24'h000888;
        step();
        in_strobe = 1'b0;
        wait_start(ok);
        repeat (3) step();
        exp_w = BANK_EN ? 9'h102 : 9'h002;
        vectors++;
        if (!ok || coeff_addr !== exp_w) begin
            miscompares++;
            $display("FAIL swap_next_pass: got ok=%b addr=%h expected 1 %h", ok, coeff_addr, exp_w);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit bad = 1'b0;
        wait_idle(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_idle_timeout: got busy=%b expected 0", busy);
        end
        for (int c = 0; c < 3; c++) begin
            in_strobe = 1'b1; in_i = 24'(c + 64); in_q = 24'(c + 96);
            step();
        end
        in_strobe = 1'b0;
        repeat (99) step();
        vectors++;
        if (fifo_level !== 3'd2 || busy !== 1'b1 || active_bank !== BANK_EN) begin
            miscompares++;
            $display("FAIL rst_pre_state: got level=%0d busy=%b bank=%b expected 2 1 %b",
                     fifo_level, busy, active_bank, BANK_EN);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (fifo_level !== 3'd0 || active_bank !== 1'b0 || coeff_addr !== 9'h000) begin
            miscompares++;
            $display("FAIL rst_mid_state: got level=%0d bank=%b addr=%h expected 0 0 000",
                     fifo_level, active_bank, coeff_addr);
        end
        for (int c = 0; c < GAP; c++) begin
            if (fir_start !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            step();
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL rst_hold: got start/busy activity during HOLD expected start=0 busy=1");
        end
        vectors++;
        if (busy !== 1'b0 || fir_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hold_end: got busy=%b start=%b expected 0 0", busy, fir_start);
        end
        step();
        vectors++;
        if (fir_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flushed: got start=%b expected 0", fir_start);
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_back_to_back();
        test_overrun();
        test_swap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qs1r_fir_ctrl.md
# qs1r_fir_ctrl

Sequencer for the dual I/Q FIR decimator stage: buffers CIC output samples in a small FIFO and issues one `start` to both FIR engines per sample. It only starts when the previous MAC pass has finished. It also drives the shared coefficient ROM/RAM read address in step with the shifting taps, and arbitrates host coefficient writes into a double-buffered coefficient RAM. It sits between the CIC decimators and the two FIR instances, one per I and Q.

## Interface
- `TAPS`, 256: taps per MAC pass; power of two.
- `AW`, 8: log2(TAPS).
- `GAP`, TAPS+8: minimum cycles from one `fir_start` to the next.
- `COEFF_LEAD`, 2: cycles after `fir_start` at which `coeff_addr` leaves 0.
- `FIFO_DEPTH`, 4: input sample FIFO depth; power of two.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `in_strobe` in 1: new I/Q sample valid, single-cycle.
- `in_i`, `in_q` in 24 each: signed samples.
- `fir_start` out 1: start pulse to both FIRs.
- `fir_in_i`, `fir_in_q` out 24 each: samples, valid in the `fir_start` cycle.
- `coeff_addr` out AW+1: coefficient read address; MSB is the bank bit.
- `coef_wr` in 1: host coefficient write.
- `coef_wr_addr` in AW: host write address.
- `coef_wr_data` in 24: host write data.
- `coef_we` out 1: RAM write enable, registered.
- `coef_waddr` out AW+1: RAM write address.
- `coef_wdata` out 24: RAM write data.
- `coef_swap` in 1: request a bank swap.
- `coef_swap_ack` out 1: one-cycle pulse when the swap takes effect.
- `active_bank` out 1: bank currently read by the FIRs.
- `busy` out 1: a MAC pass is in flight.
- `fifo_level` out log2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overrun` out 1: sticky flag, set on a dropped sample.
- `ovr_clr` in 1: clears `overrun`.

## Operation
- FIFO: `in_strobe` pushes {i,q}.
  - Push while full: the sample is dropped and `overrun` is set.
  - Push and pop in the same cycle are both honoured. Full plus push plus pop gives no drop.
- FSM states:
  - `HOLD`: entered from reset. A GAP-cycle counter runs out, because the FIRs have no reset and may still be mid-pass. Then go to `IDLE`.
  - `IDLE`: on a non-empty FIFO, pop the head, register it onto `fir_in_*`, pulse `fir_start`, load the counter with 0, and go to `RUN`.
  - `RUN`: the counter increments each cycle. At counter == GAP-1, go to `IDLE`. A start may therefore issue exactly GAP cycles after the previous one.
- `busy` = state != `IDLE`.
- `coeff_addr[AW-1:0]`:
  - 0 outside `RUN`.
  - In `RUN`, it equals counter-COEFF_LEAD+1 while that value lies in 1..TAPS-1, and 0 otherwise.
  - The tap index is mod TAPS and never exceeds TAPS-1.
- `coeff_addr[AW]` = `active_bank`.
- Coefficient writes:
  - `coef_wr` is forwarded one cycle later as `coef_we`, with `coef_waddr` = {~active_bank, coef_wr_addr}. Host writes always target the inactive bank.
- Bank swap:
  - `coef_swap` sets a pending flag. The swap executes only in a cycle that is in `IDLE` with no start issuing, or in `HOLD`.
  - On executing: toggle `active_bank`, pulse `coef_swap_ack`, clear pending.
  - A swap is never applied during `RUN`.
  - `coef_wr` in the cycle the swap executes still targets the pre-swap inactive bank.
- `ovr_clr` in the same cycle as an overflow: set wins.

## Timing
- Reset values:
  - `fir_start`, `coef_we`, `coef_swap_ack`, `overrun`: 0.
  - `fir_in_*`: 0.
  - `coeff_addr`: 0.
  - `active_bank`: 0.
  - `fifo_level`: 0.
  - `busy`: 1, since the FSM is in `HOLD`.
- Reset mid-pass: the FIFO is flushed, pending swap cleared, bank restored to 0, and the FSM re-enters `HOLD` for GAP cycles.
- Latency from `in_strobe` into an empty FIFO, with the FSM in `IDLE`, to `fir_start`: 2 cycles.
- All outputs are registered.

## Configuration
- `QS1R_FIR_CTRL_BANK_EN` defined:
  - Two coefficient banks, with swap behaviour as above.
- Not defined:
  - Single bank. `coeff_addr` MSB, `coef_waddr` MSB and `active_bank` are all 0.
  - `coef_swap` is ignored and `coef_swap_ack` is held at 0.
  - Host writes go directly to the live bank.

## Structure
- Shared package `qs1r_fir_pkg` holds:
  - the sample width constant 24;
  - the FSM state enum {HOLD, IDLE, RUN};
  - the default TAPS/GAP constants.
- Sub-module `qs1r_fir_ctrl_fifo` is a synchronous FIFO carrying 48-bit {i,q} words. It has level and full/empty outputs and simultaneous push/pop support.

## Test plan
- Release reset, then strobe one sample (i=0x000123, q=0xFFFEDC) in cycle 5.
  - `fir_start` is held off until HOLD ends at cycle GAP.
  - It then pulses once with `fir_in_i`=0x000123 and `fir_in_q`=0xFFFEDC.
- Strobe 3 samples back-to-back while idle.
  - Three `fir_start` pulses occur exactly GAP=264 cycles apart.
  - Per pass, `coeff_addr` goes 0,1..255,0 starting at counter COEFF_LEAD.
- Strobe 6 samples within a single pass.
  - 4 samples are queued, giving `fifo_level`=4, and 1 is consumed by the start.
  - 1 sample is dropped and `overrun`=1.
  - `ovr_clr` then returns `overrun` to 0.
- Write coef_wr_addr=0x10 with data 0x7FFFFF, then assert `coef_swap` mid-`RUN`. With BANK_EN defined:
  - `coef_waddr`=0x110.
  - `coef_swap_ack` fires only at the first `IDLE` cycle.
  - `coeff_addr[8]`=1 on the next pass.
- Assert `reset` at counter 100 of a pass with 2 samples queued.
  - `fifo_level`=0, `active_bank`=0, `fir_start` stays low for GAP cycles, and `busy`=1 throughout.
- Rebuild without the macro and toggle `coef_swap`.
  - `coef_swap_ack` stays 0 and `coeff_addr[8]` stays 0.
